// File: rtl/npc_pred_pkg.sv
// npc_pred_pkg: counter encodings, saturating arithmetic and BTB width helpers
package npc_pred_pkg;
  localparam logic [31:0] SNT = 32'd0;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int entries);
    return 30 - $clog2(entries);
  endfunction
  function automatic logic [31:0] ctr_wt(input int bits);
    return 32'd1 << (bits - 1);
  endfunction
  function automatic logic [31:0] ctr_max(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input int bits);
    return (c == ctr_max(bits)) ? c : c + 32'd1;
  endfunction
  function automatic logic [31:0] sat_dec(input logic [31:0] c);
    return (c == SNT) ? c : c - 32'd1;
  endfunction
endpackage

// File: rtl/npc_btb_table.sv
// npc_btb_table: direct-mapped BTB storage with one lookup port and one training port
module npc_btb_table import npc_pred_pkg::*; #(
  parameter int ENTRIES = 64,
  parameter int CTR_BITS = 2,
  localparam int IDX_W = idx_w(ENTRIES),
  localparam int TAG_W = tag_w(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic                o_rd_valid,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic [31:0]         o_rd_target,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_wr_en,
  input  logic                i_wr_taken,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [TAG_W-1:0]    i_wr_tag,
  input  logic [31:0]         i_wr_target
);
  logic                r_valid  [ENTRIES];
  logic [TAG_W-1:0]    r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic                w_wr_hit;
  logic [CTR_BITS-1:0] w_inc, w_dec, w_wt;
  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];
  assign o_rd_ctr    = r_ctr[i_rd_idx];
  assign w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
  assign w_inc = CTR_BITS'(sat_inc(32'(r_ctr[i_wr_idx]), CTR_BITS));
  assign w_dec = CTR_BITS'(sat_dec(32'(r_ctr[i_wr_idx])));
  assign w_wt  = CTR_BITS'(ctr_wt(CTR_BITS));
  // a taken miss evicts whatever lives at the index; a not-taken miss leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        r_valid[k] <= 1'b0;
        r_ctr[k]   <= '0;
      end
    end else if (i_wr_en && i_wr_taken) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_ctr[i_wr_idx]   <= w_wr_hit ? w_inc : w_wt;
    end else if (i_wr_en && w_wr_hit) begin
      r_ctr[i_wr_idx] <= w_dec;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && i_wr_en && i_wr_taken) begin
      r_tag[i_wr_idx]    <= i_wr_tag;
      r_target[i_wr_idx] <= i_wr_target;
    end
  end
endmodule

// File: rtl/npc_predictor_unit.sv
// npc_predictor_unit: next-PC mux with BTB prediction, EX-stage training,
// misprediction recovery and branch performance counters
module npc_predictor_unit import npc_pred_pkg::*; #(
  parameter int ENTRIES = 64,
  parameter int CTR_BITS = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [31:0]      pc_if,
  input  logic [31:0]      pc4_if,
  output logic             pred_taken_if,
  output logic [31:0]      pred_target_if,
  input  logic             ex_br,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             jal,
  input  logic [31:0]      jal_target,
  input  logic             jalr,
  input  logic [31:0]      jalr_target,
  output logic [31:0]      npc,
  output logic             flush,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(ENTRIES);
  logic                w_rd_valid, w_hit, w_upd;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [31:0]         w_rd_target;
  logic [CTR_BITS-1:0] w_rd_ctr;
  logic [CNT_W-1:0]    r_br, r_mp;
  npc_btb_table #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (pc_if[IDX_W+1:2]),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_target(w_rd_target),
    .o_rd_ctr   (w_rd_ctr),
    .i_wr_en    (w_upd),
    .i_wr_taken (ex_taken),
    .i_wr_idx   (ex_pc[IDX_W+1:2]),
    .i_wr_tag   (ex_pc[31:IDX_W+2]),
    .i_wr_target(ex_target)
  );
  assign w_hit          = w_rd_valid && (w_rd_tag == pc_if[31:IDX_W+2]);
  assign pred_taken_if  = w_hit && w_rd_ctr[CTR_BITS-1];
  assign pred_target_if = w_hit ? w_rd_target : 32'd0;
  assign mispredict = ex_br && ((ex_taken != ex_pred_taken) ||
                      (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign npc = jalr                      ? jalr_target :
               (mispredict && ex_taken)  ? ex_target :
               mispredict                ? ex_pc + 32'd4 :
               jal                       ? jal_target :
               pred_taken_if             ? pred_target_if : pc4_if;
  assign flush = jalr || mispredict || jal;
  assign w_upd = ex_br && !stall;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_br <= '0;
      r_mp <= '0;
    end else begin
      if (w_upd && !(&r_br)) r_br <= r_br + 1'b1;
      if (w_upd && mispredict && !(&r_mp)) r_mp <= r_mp + 1'b1;
    end
  end
  assign br_count = r_br;
  assign mp_count = r_mp;
endmodule

// File: doc/npc_predictor_unit.md
Name: npc_predictor_unit

Overview:
- Next-generation next-PC unit for the RV32I 5-stage core.
- Folds a parametrised direct-mapped branch target buffer (BTB) with per-entry saturating counters into the next-PC priority mux.
- IF-stage lookup is combinational. EX-stage branch resolution trains the table and drives misprediction recovery.
- Exports branch counts and mispredict counts for performance analysis.

Parameters:
ENTRIES, 64, BTB depth; power of two, at least 2
CTR_BITS, 2, width of each saturating direction counter, at least 1
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous reset, active-low
stall  in  1  pipeline stall; blocks all table and counter updates
pc_if  in  32  fetch-stage PC
pc4_if  in  32  pc_if + 4
pred_taken_if  out  1  fetch-stage prediction: taken
pred_target_if  out  32  predicted target; valid when pred_taken_if=1
ex_br  in  1  EX holds a conditional branch
ex_pc  in  32  PC of the EX instruction
ex_taken  in  1  resolved branch outcome
ex_target  in  32  resolved branch target
ex_pred_taken  in  1  prediction carried from IF for the EX instruction
ex_pred_target  in  32  predicted target carried from IF
jal  in  1  jal resolved (ID)
jal_target  in  32  jal target
jalr  in  1  jalr resolved (EX)
jalr_target  in  32  jalr target
npc  out  32  next PC
flush  out  1  redirect; squash younger instructions
mispredict  out  1  EX branch mispredicted
br_count  out  CNT_W  conditional branches retired from EX
mp_count  out  CNT_W  mispredicted branches

Behaviour:
- Widths: IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2].
- Each BTB entry holds valid, tag, target[31:0] and ctr[CTR_BITS-1:0].
- Lookup (combinational):
  - hit = valid[idx] and tag match.
  - pred_taken_if = hit and ctr MSB.
  - pred_target_if = entry target; 0 when there is no hit.
- Mispredict (combinational): mispredict = ex_br and one of:
  - ex_taken differs from ex_pred_taken;
  - ex_taken, ex_pred_taken and ex_target differ from ex_pred_target.
- npc priority:
  1. jalr -> jalr_target
  2. mispredict with ex_taken=1 -> ex_target
  3. mispredict with ex_taken=0 -> ex_pc+4
  4. jal -> jal_target
  5. pred_taken_if -> pred_target_if
  6. otherwise pc4_if
- flush = jalr or mispredict or jal.
- Update (registered, on the clk edge when ex_br=1, stall=0, rst_n=1):
  - Taken, EX-index miss: allocate. Set valid, tag, target; ctr = weakly taken (1 followed by CTR_BITS-1 zeros).
  - Taken, hit: write target; ctr saturating increment (stays at all-ones).
  - Not taken, hit: ctr saturating decrement (stays at 0).
  - Not taken, miss: no change; no allocation.
- Counters: br_count increments on every update cycle; mp_count increments when mispredict is also 1. Both saturate at all-ones.
- Timing:
  - Update latency is 1 cycle. An IF lookup in the same cycle as a write to the same index sees the old entry; there is no bypass.
  - IF and EX may reference the same index with different tags; the EX write wins the entry.
- Reset: rst_n=0 at an edge clears all valid bits, all ctr values, br_count and mp_count. Targets and tags are not reset.
  - Reset asserted mid-operation discards any pending update that cycle.
  - Combinational outputs follow their inputs. After reset, pred_taken_if=0 until the first allocation.
- stall=1: npc, flush and mispredict are still driven; the table and counters are frozen.

Decomposition:
- Shared package npc_pred_pkg holds:
  - ctr encoding constants: SNT=0, weakly-taken init value, saturation max;
  - sat_inc and sat_dec functions;
  - idx/tag width helper functions.
- One sub-module, npc_btb_table: valid/tag/target/ctr storage with 1 combinational read port, 1 synchronous write port and synchronous valid/ctr clear.
- Top level holds the mispredict logic, npc mux and performance counters.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then pc_if=0x100 -> pred_taken_if=0, npc=0x104, br_count=0, mp_count=0.
- First encounter of a taken branch at 0x100 (ex_taken=1, ex_target=0x80, ex_pred_taken=0):
  - Same cycle: mispredict=1, flush=1, npc=0x80.
  - Next cycle with pc_if=0x100: pred_taken_if=1, pred_target_if=0x80.
- Counter hysteresis at 0x100 after allocation:
  - One not-taken -> ctr=01, prediction not-taken.
  - Two taken -> ctr=11.
  - One not-taken -> ctr=10, still predicts taken.
  - Four further not-taken -> ctr saturates at 00.
- Aliasing with ENTRIES=64: allocate 0x100 then 0x200 (same index, different tag) -> lookup of 0x100 misses, lookup of 0x200 hits.
- Priority with jalr=1, a mispredicted branch, jal=1 and pred_taken_if=1 all together -> npc=jalr_target.
  - Dropping jalr -> npc follows the branch recovery.
  - Clearing the mispredict -> npc=jal_target.
- Stall, saturation and mid-run reset:
  - A mispredicted branch held in EX with stall=1 for 3 cycles -> no table change, mp_count unchanged; it is counted once when stall=0.
  - With CNT_W=4, 17 branches -> br_count=15.
  - rst_n=0 mid-run clears all entries.
